// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel divider, frame/game pulses and registered blanked colour and syncs
module vga_timing_gen #(
  parameter int   CLK_DIV     = 2,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b0,
  parameter int   TICK_FRAMES = 2,
  parameter int   CW          = 10
) (
  input  logic          mclk,
  input  logic          clr,
  input  logic [7:0]    rgb_in,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          vidon,
  output logic          pix_en,
  output logic          frame_start,
  output logic          game_tick,
  output logic          hsync,
  output logic          vsync,
  output logic [2:0]    red,
  output logic [2:0]    green,
  output logic [1:0]    blue
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int FW = TICK_FRAMES > 1 ? $clog2(TICK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FC_MAX = FW'(TICK_FRAMES - 1);
  localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SS = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          h_end, v_end;
  // pix_en is masked during clr so no pulse escapes while the raster is being restarted
  always_comb begin
    pix_en      = !clr && div_q == DIV_MAX;
    h_end       = hc_q == H_MAX;
    v_end       = vc_q == V_MAX;
    vidon       = hc_q < H_ACT && vc_q < V_ACT;
    frame_start = pix_en && h_end && v_end;
    game_tick   = frame_start && fc_q == FC_MAX;
    div_d       = div_q == DIV_MAX ? '0 : div_q + 1'b1;
    hc_d        = !pix_en ? hc_q : h_end ? '0 : hc_q + 1'b1;
    vc_d        = !(pix_en && h_end) ? vc_q : v_end ? '0 : vc_q + 1'b1;
    fc_d        = !frame_start ? fc_q : fc_q == FC_MAX ? '0 : fc_q + 1'b1;
    hs_d        = !pix_en ? hs_q : (hc_q >= H_SS && hc_q <= H_SE) ? H_POL : ~H_POL;
    vs_d        = !pix_en ? vs_q : (vc_q >= V_SS && vc_q <= V_SE) ? V_POL : ~V_POL;
    rgb_d       = !pix_en ? rgb_q : vidon ? rgb_in : 8'h00;
  end
  always_ff @(posedge mclk) begin
    if (clr) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      fc_q  <= '0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      fc_q  <= fc_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end
  assign hc    = hc_q;
  assign vc    = vc_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign red   = rgb_q[7:5];
  assign green = rgb_q[4:2];
  assign blue  = rgb_q[1:0];
endmodule
